// File: rtl/invaders_pkg.sv
// invaders_pkg: shared geometry constants, formation FSM states and the alive-bitmap type.
package invaders_pkg;
  localparam int NUM_ROWS    = 6;
  localparam int MAX_COLS    = 10;
  localparam int COL_PITCH   = 64;
  localparam int SPRITE_W    = 32;
  localparam int SCREEN_W    = 640;
  localparam int ANIM_FRAME1 = 8;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SCAN, S_MOVE} formation_state_t;
  typedef logic [MAX_COLS-1:0][NUM_ROWS-1:0] status_t;
endpackage

// File: rtl/frame_edge_sync.sv
// frame_edge_sync: two-flop synchroniser on the VSYNC-derived level plus a one-cycle rising-edge pulse.
module frame_edge_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic i_level,
  output logic o_tick
);
  logic [2:0] r_sync;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) r_sync <= '0;
    else r_sync <= {r_sync[1:0], i_level};
  assign o_tick = r_sync[1] & ~r_sync[2];
endmodule

// File: rtl/enemy_formation.sv
// enemy_formation: invader grid alive bitmap, march offset with edge reversal, animation select and hit retirement.
// Optional macro SPEEDUP_EN shortens the march period as the population shrinks.
module enemy_formation
  import invaders_pkg::*;
#(
  parameter int NUM_COLS    = 8,
  parameter int STEP_PX     = 4,
  parameter int STEP_FRAMES = 16,
  parameter int ANIM_STEPS  = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       new_wave,
  input  logic       hit_valid,
  input  logic [3:0] hit_col,
  input  logic [2:0] hit_row,
  output logic       hit_ack,
  output logic       hit_kill,
  output logic [9:0] enemy_offset,
  output logic [7:0] animation_offset,
  output status_t    enemy_status,
  output logic [5:0] enemies_left,
  output logic       wave_cleared
);
  localparam int TOTAL = NUM_ROWS * NUM_COLS;
  formation_state_t r_state, w_next;
  status_t r_status, r_snap, w_full;
  logic [5:0] r_left;
  logic [9:0] r_offset;
  logic r_dir_left, r_anim, r_ack, r_kill;
  logic [15:0] r_fcnt, w_period;
  logic [7:0] r_step;
  logic [3:0] r_col, r_rmost;
  logic [10:0] w_right_edge;
  logic w_tick, w_last, w_period_end, w_accept, w_kill, w_can_right, w_can_left, w_anim_end;

  frame_edge_sync u_sync (.Clk(Clk), .Reset(Reset), .i_level(frame_clk), .o_tick(w_tick));

`ifdef SPEEDUP_EN
  logic [15:0] r_period, w_speed;
  logic [8:0] w_pop;
  assign w_pop = 9'(r_left);
  always_comb begin
    w_speed = ((w_pop << 3) <= 9'(TOTAL)) ? 16'(STEP_FRAMES >> 3) :
              ((w_pop << 2) <= 9'(TOTAL)) ? 16'(STEP_FRAMES >> 2) :
              ((w_pop << 1) <= 9'(TOTAL)) ? 16'(STEP_FRAMES >> 1) : 16'(STEP_FRAMES);
    if (w_speed == '0) w_speed = 16'd1;
  end
  assign w_period = r_period;
`else
  assign w_period = 16'(STEP_FRAMES);
`endif

  always_comb
    for (int c = 0; c < MAX_COLS; c++) w_full[c] = (c < NUM_COLS) ? '1 : '0;

  assign w_last       = r_col == 4'(NUM_COLS - 1);
  assign w_period_end = r_fcnt >= w_period - 16'd1;
  assign w_accept     = hit_valid && !r_ack;
  assign w_kill       = w_accept && r_state != S_IDLE && hit_col < 4'(NUM_COLS) &&
                        hit_row < 3'(NUM_ROWS) && r_status[hit_col][hit_row];
  // Right limit uses the rightmost live column so a thinned grid marches further.
  assign w_right_edge = 11'(r_offset) + 11'(r_rmost) * 11'(COL_PITCH) + 11'(SPRITE_W + STEP_PX);
  assign w_can_right  = w_right_edge <= 11'(SCREEN_W);
  assign w_can_left   = r_offset >= 10'(STEP_PX);
  assign w_anim_end   = r_step >= 8'(ANIM_STEPS - 1);

  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (new_wave) w_next = S_WAIT;
    else
      case (r_state)
        S_WAIT:  w_next = (r_left == '0) ? S_IDLE : w_tick ? S_SCAN : S_WAIT;
        S_SCAN:  w_next = (r_left == '0) ? S_IDLE : !w_last ? S_SCAN : w_period_end ? S_MOVE : S_WAIT;
        S_MOVE:  w_next = S_WAIT;
        default: w_next = r_state;
      endcase
  end

  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      r_status   <= '0;
      r_snap     <= '0;
      r_left     <= '0;
      r_offset   <= '0;
      r_dir_left <= 1'b0;
      r_anim     <= 1'b0;
      r_ack      <= 1'b0;
      r_kill     <= 1'b0;
      r_fcnt     <= '0;
      r_step     <= '0;
      r_col      <= '0;
      r_rmost    <= '0;
`ifdef SPEEDUP_EN
      r_period   <= 16'(STEP_FRAMES);
`endif
    end else if (new_wave) begin
      r_status   <= w_full;
      r_left     <= 6'(TOTAL);
      r_offset   <= '0;
      r_dir_left <= 1'b0;
      r_anim     <= 1'b0;
      r_ack      <= 1'b0;
      r_kill     <= 1'b0;
      r_fcnt     <= '0;
      r_step     <= '0;
`ifdef SPEEDUP_EN
      r_period   <= 16'(STEP_FRAMES);
`endif
    end else begin
      r_ack  <= w_accept;
      r_kill <= w_kill;
      if (w_kill) begin
        r_status[hit_col][hit_row] <= 1'b0;
        r_left <= r_left - 6'd1;
      end
      if (r_state == S_WAIT && w_tick) begin
        r_snap  <= r_status;
        r_col   <= '0;
        r_rmost <= '0;
      end
      if (r_state == S_SCAN) begin
        r_col <= r_col + 4'd1;
        if (|r_snap[r_col]) r_rmost <= r_col;
        if (w_last) r_fcnt <= w_period_end ? '0 : r_fcnt + 16'd1;
      end
      if (r_state == S_MOVE) begin
        r_step <= w_anim_end ? '0 : r_step + 8'd1;
        if (w_anim_end) r_anim <= ~r_anim;
        if (!r_dir_left) begin
          if (w_can_right) r_offset <= r_offset + 10'(STEP_PX);
          else r_dir_left <= 1'b1;
        end else begin
          if (w_can_left) r_offset <= r_offset - 10'(STEP_PX);
          else r_dir_left <= 1'b0;
        end
`ifdef SPEEDUP_EN
        r_period <= w_speed;
`endif
      end
    end

  assign hit_ack          = r_ack;
  assign hit_kill         = r_kill;
  assign enemy_offset     = r_offset;
  assign animation_offset = r_anim ? 8'(ANIM_FRAME1) : 8'd0;
  assign enemy_status     = r_status;
  assign enemies_left     = r_left;
  assign wave_cleared     = r_left == '0;
endmodule
